// File: rtl/shift_4094_chain.sv
// shift_4094_chain: serial driver for a daisy chain of CHAIN 4094-type shift/latch registers.
// Optional QS readback is built in when SHIFT_4094_CHAIN_READBACK_EN is defined.
module shift_4094_chain #(
  parameter int CHAIN     = 2,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [8*CHAIN-1:0] data_in,
  output logic               ready,
  output logic               busy,
  output logic               register_clock,
  output logic               data_out,
  output logic               strobe,
  output logic               oe,
  input  logic               qs_in,
  output logic [8*CHAIN-1:0] rb_data,
  output logic               rb_valid,
  output logic               rb_mismatch
);

  localparam int W  = 8 * CHAIN;
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, STROBE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            reg_clk_q, reg_clk_d;
  logic            data_out_q, data_out_d;
  logic            strobe_q, strobe_d;
  logic            oe_q, oe_d;
  logic            phase_last;
  logic            bit_last;
  logic            accept;

  assign phase_last = (phase_q == PW'(CLK_DIV - 1));
  assign bit_last   = (bit_q == BW'(W - 1));
  assign accept     = wr_en && !pend_full_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    oe_d        = oe_q;
    data_out_d  = data_out_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (pend_full_q) begin
          sh_d        = pend_q;
          pend_full_d = 1'b0;
          bit_d       = '0;
          state_d     = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          phase_d = '0;
          sh_d    = (MSB_FIRST != 0) ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};
          if (bit_last) begin
            bit_d   = '0;
            state_d = STROBE;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      STROBE: begin
        if (phase_last) begin
          phase_d = '0;
          oe_d    = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The pending buffer is only written while empty, so it never collides with the IDLE load.
    if (accept) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end

    // data_out only moves when a new bit period starts.
    if (state_d == SHIFT_LO && state_q != SHIFT_LO)
      data_out_d = (MSB_FIRST != 0) ? sh_d[W-1] : sh_d[0];

    reg_clk_d = (state_d == SHIFT_HI);
    strobe_d  = (state_d == STROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      pend_full_q <= 1'b0;
      reg_clk_q   <= 1'b0;
      data_out_q  <= 1'b0;
      strobe_q    <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      pend_full_q <= pend_full_d;
      reg_clk_q   <= reg_clk_d;
      data_out_q  <= data_out_d;
      strobe_q    <= strobe_d;
      oe_q        <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    pend_q <= pend_d;
  end

  assign ready          = ~pend_full_q;
  assign busy           = (state_q != IDLE) | pend_full_q;
  assign register_clock = reg_clk_q;
  assign data_out       = data_out_q;
  assign strobe         = strobe_q;
  assign oe             = oe_q;

`ifdef SHIFT_4094_CHAIN_READBACK_EN
  logic [W-1:0] rb_shift_q, rb_shift_d;
  logic [W-1:0] rb_data_q, rb_data_d;
  logic [W-1:0] cur_word_q, cur_word_d;
  logic [W-1:0] prev_word_q, prev_word_d;
  logic         have_cur_q, have_cur_d;
  logic         have_prev_q, have_prev_d;
  logic         rb_valid_q, rb_valid_d;
  logic         rb_mis_q, rb_mis_d;
  logic         load;
  logic         strobe_entry;

  assign load         = (state_q == IDLE) && pend_full_q;
  assign strobe_entry = (state_d == STROBE) && (state_q != STROBE);

  always_comb begin
    rb_shift_d  = rb_shift_q;
    rb_data_d   = rb_data_q;
    cur_word_d  = cur_word_q;
    prev_word_d = prev_word_q;
    have_cur_d  = have_cur_q;
    have_prev_d = have_prev_q;
    rb_mis_d    = rb_mis_q;
    rb_valid_d  = strobe_entry;

    if (load) begin
      cur_word_d  = pend_q;
      prev_word_d = cur_word_q;
      have_cur_d  = 1'b1;
      have_prev_d = have_cur_q;
    end
    // QS is taken just before the rising register_clock, in the same order bits go in.
    if (state_q == SHIFT_LO && phase_last)
      rb_shift_d = (MSB_FIRST != 0) ? {rb_shift_q[W-2:0], qs_in} : {qs_in, rb_shift_q[W-1:1]};
    if (strobe_entry) begin
      rb_data_d = rb_shift_q;
      rb_mis_d  = have_prev_q && (rb_shift_q != prev_word_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data_q   <= '0;
      have_cur_q  <= 1'b0;
      have_prev_q <= 1'b0;
      rb_valid_q  <= 1'b0;
      rb_mis_q    <= 1'b0;
    end else begin
      rb_data_q   <= rb_data_d;
      have_cur_q  <= have_cur_d;
      have_prev_q <= have_prev_d;
      rb_valid_q  <= rb_valid_d;
      rb_mis_q    <= rb_mis_d;
    end
  end

  always_ff @(posedge clk) begin
    rb_shift_q  <= rb_shift_d;
    cur_word_q  <= cur_word_d;
    prev_word_q <= prev_word_d;
  end

  assign rb_data     = rb_data_q;
  assign rb_valid    = rb_valid_q;
  assign rb_mismatch = rb_mis_q;
`else
  logic unused_qs;
  assign unused_qs   = qs_in;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
  assign rb_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_4094_chain.sv
// Directed bench for shift_4094_chain: a 2-device chain (CLK_DIV=2) and a 1-device LSB-first chain (CLK_DIV=1).
module tb_shift_4094_chain;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wr_a, ready_a, busy_a, rc_a, do_a, st_a, oe_a, qs_a, rbv_a, rbm_a;
  logic [15:0] din_a, rbd_a;
  logic        wr_b, ready_b, busy_b, rc_b, do_b, st_b, oe_b, qs_b, rbv_b, rbm_b;
  logic [7:0]  din_b, rbd_b;

  shift_4094_chain #(.CHAIN(2), .CLK_DIV(2), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .data_in(din_a), .ready(ready_a), .busy(busy_a),
    .register_clock(rc_a), .data_out(do_a), .strobe(st_a), .oe(oe_a), .qs_in(qs_a),
    .rb_data(rbd_a), .rb_valid(rbv_a), .rb_mismatch(rbm_a));

  shift_4094_chain #(.CHAIN(1), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .data_in(din_b), .ready(ready_b), .busy(busy_b),
    .register_clock(rc_b), .data_out(do_b), .strobe(st_b), .oe(oe_b), .qs_in(qs_b),
    .rb_data(rbd_b), .rb_valid(rbv_b), .rb_mismatch(rbm_b));

  // Model of the 16-bit chain behind dut_a: QS is the last stage.
  logic [15:0] chain = '0;
  logic        rc_prev = 1'b0;
  logic        stuck = 1'b0;
  logic        qs_rand = 1'b0;
  always @(negedge clk) begin
    if (rc_a && !rc_prev) chain <= {chain[14:0], do_a};
    rc_prev <= rc_a;
    qs_rand <= 1'($urandom_range(0, 1));
  end
`ifdef SHIFT_4094_CHAIN_READBACK_EN
  assign qs_a = stuck ? 1'b0 : chain[15];
`else
  assign qs_a = qs_rand;
`endif
  assign qs_b = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic        rc_t [0:199];
  logic        do_t [0:199];
  logic        st_t [0:199];
  logic        oe_t [0:199];
  logic        rdy_t[0:199];
  logic        bsy_t[0:199];
  logic        rbv_t[0:199];
  logic        rbm_t[0:199];
  logic [15:0] rbd_t[0:199];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_a(input int k);
    rc_t[k] = rc_a; do_t[k] = do_a; st_t[k] = st_a; oe_t[k] = oe_a;
    rdy_t[k] = ready_a; bsy_t[k] = busy_a; rbv_t[k] = rbv_a; rbm_t[k] = rbm_a; rbd_t[k] = rbd_a;
  endtask

  task automatic sample_b(input int k);
    rc_t[k] = rc_b; do_t[k] = do_b; st_t[k] = st_b; oe_t[k] = oe_b;
    rdy_t[k] = ready_b; bsy_t[k] = busy_b; rbv_t[k] = rbv_b; rbm_t[k] = rbm_b; rbd_t[k] = 16'(rbd_b);
  endtask

  // Write w to dut_a in cycle 0 and record n cycles.
  task automatic frame_a(input logic [15:0] w, input int n);
    wr_a = 1'b1; din_a = w;
    sample_a(0);
    for (int k = 1; k < n; k++) begin
      step();
      if (k == 1) wr_a = 1'b0;
      sample_a(k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, first, cnt, e1, e17, bsy_low;
    logic [15:0] bits, bits2;
    logic acc_v, acc_m;
    logic [15:0] acc_d;

    rst_n = 1'b0; wr_a = 1'b0; din_a = '0; wr_b = 1'b0; din_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_rc", rc_a, 0);
    check("rst_data_out", do_a, 0);
    check("rst_strobe", st_a, 0);
    check("rst_oe", oe_a, 0);
    check("rst_rb", {rbd_a, rbv_a, rbm_a}, 0);
    rst_n = 1'b1;
    step();

    // Single frame of 16'hA5C3
    frame_a(16'hA5C3, 200);
    n = 0; first = -1; bits = '0; cnt = 0;
    for (int k = 1; k < 200; k++) begin
      if (rc_t[k] && !rc_t[k-1]) begin
        if (first < 0) first = k;
        bits = {bits[14:0], do_t[k]};
        n++;
      end
      if (st_t[k]) cnt++;
    end
    check("t1_edges", n, 16);
    check("t1_first_edge", first, 4);
    check("t1_bits", bits, 16'hA5C3);
    check("t1_ready_c1", rdy_t[1], 0);
    check("t1_ready_c2", rdy_t[2], 1);
    check("t1_strobe_cnt", cnt, 2);
    check("t1_strobe_65_68", {st_t[65], st_t[66], st_t[67], st_t[68]}, 4'b0110);
    check("t1_oe_67_68", {oe_t[67], oe_t[68]}, 2'b01);
    check("t1_busy_67_68", {bsy_t[67], bsy_t[68]}, 2'b10);

    // Back-to-back frames; the third write hits ready=0 and must be dropped
    wr_a = 1'b1; din_a = 16'h0001;
    sample_a(0);
    for (int k = 1; k < 200; k++) begin
      step();
      case (k)
        1: wr_a = 1'b0;
        2: begin wr_a = 1'b1; din_a = 16'h8000; end
        3: begin wr_a = 1'b1; din_a = 16'hFFFF; end
        4: wr_a = 1'b0;
        default: ;
      endcase
      sample_a(k);
    end
    n = 0; e1 = -1; e17 = -1; bits = '0; bits2 = '0;
    for (int k = 1; k < 200; k++) begin
      if (rc_t[k] && !rc_t[k-1]) begin
        if (n == 0) e1 = k;
        if (n == 16) e17 = k;
        if (n < 16) bits = {bits[14:0], do_t[k]};
        else bits2 = {bits2[14:0], do_t[k]};
        n++;
      end
    end
    check("t2_ready_c2", rdy_t[2], 1);
    check("t2_ready_c3", rdy_t[3], 0);
    check("t2_edges", n, 32);
    check("t2_frame_gap", e17 - e1, 67);
    check("t2_word1", bits, 16'h0001);
    check("t2_word2", bits2, 16'h8000);

    // One-device LSB-first chain at CLK_DIV=1
    wr_b = 1'b1; din_b = 8'h01;
    sample_b(0);
    for (int k = 1; k < 30; k++) begin
      step();
      if (k == 1) wr_b = 1'b0;
      sample_b(k);
    end
    cnt = 0; first = -1; bsy_low = -1;
    for (int k = 1; k < 30; k++) begin
      if (do_t[k]) cnt++;
      if (rc_t[k] && !rc_t[k-1] && first < 0) first = k;
      if (!bsy_t[k] && bsy_low < 0) bsy_low = k;
    end
    check("t3_data_bit0", {do_t[1], do_t[2], do_t[3], do_t[4]}, 4'b0110);
    check("t3_data_ones", cnt, 2);
    check("t3_first_edge", first, 3);
    check("t3_strobe", {st_t[17], st_t[18], st_t[19]}, 3'b010);
    check("t3_frame_len", bsy_low - 2, 17);

    // Reset during bit 5 of a frame, with a second word pending
    wr_a = 1'b1; din_a = 16'hFFFF;
    for (int k = 1; k <= 24; k++) begin
      step();
      case (k)
        1: wr_a = 1'b0;
        2: begin wr_a = 1'b1; din_a = 16'h00FF; end
        3: wr_a = 1'b0;
        default: ;
      endcase
    end
    check("t4_pre_state", {rc_a, do_a, oe_a, ready_a}, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_outs", {rc_a, st_a, oe_a, do_a}, 4'b0000);
    check("t4_async_ready_busy", {ready_a, busy_a}, 2'b10);
    step();
    step();
    #3 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rc_a || st_a || oe_a || do_a || busy_a || !ready_a) cnt++;
    end
    check("t4_no_activity", cnt, 0);

`ifdef SHIFT_4094_CHAIN_READBACK_EN
    frame_a(16'h1234, 80);
    cnt = 0;
    for (int k = 0; k < 80; k++) if (rbv_t[k]) cnt++;
    check("t5_first_valid_cnt", cnt, 1);
    check("t5_first_mismatch", rbm_t[79], 0);
    frame_a(16'hFFFF, 80);
    cnt = 0;
    for (int k = 0; k < 80; k++) if (rbv_t[k]) cnt++;
    check("t5_valid_cnt", cnt, 1);
    check("t5_valid_at_66", rbv_t[66], 1);
    check("t5_rb_data", rbd_t[79], 16'h1234);
    check("t5_mismatch", rbm_t[79], 0);
    stuck = 1'b1;
    frame_a(16'h0000, 80);
    check("t5_stuck_data", rbd_t[79], 16'h0000);
    check("t5_stuck_mismatch", rbm_t[79], 1);
    stuck = 1'b0;
`else
    acc_v = 1'b0; acc_m = 1'b0; acc_d = '0;
    frame_a(16'h1234, 80);
    for (int k = 0; k < 80; k++) begin
      acc_v |= rbv_t[k]; acc_m |= rbm_t[k]; acc_d |= rbd_t[k];
    end
    frame_a(16'h5A5A, 80);
    for (int k = 0; k < 80; k++) begin
      acc_v |= rbv_t[k]; acc_m |= rbm_t[k]; acc_d |= rbd_t[k];
    end
    check("t5_rb_data_zero", acc_d, 16'h0000);
    check("t5_rb_valid_zero", acc_v, 0);
    check("t5_rb_mismatch_zero", acc_m, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
